// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Program loader and instruction fetch unit. A byte-wide loader fills a small
//   program memory (high byte of each word first). Execution then streams
//   memory words to the decoder one per cycle. Jumps and stops insert NOP
//   bubbles.
//
// Parameters
//   NOP_WORD   instruction word issued during bubbles, idle and reset
//   PM_DEPTH   number of 16-bit program memory words (5-bit addressing)
//
// Ports
//   i_clk          clock, all state updates on the rising edge
//   i_rst          synchronous active-high reset
//   i_load         pulse: start program load (honoured in IDLE only)
//   i_start        pulse: run from address 0 (honoured in IDLE only)
//   i_stop         pulse: abort load or run, return to IDLE
//   i_ld_data      loader byte, high byte of each word first
//   i_ld_valid     loader byte valid
//   i_ld_last      marks the low byte of the final program word
//   o_ld_ready     loader may transfer (byte taken on valid && ready)
//   i_jmp          jump request from decoder (combinational from o_instr_out)
//   i_jmp_addr     jump target address
//   o_instr_out    registered instruction word to decoder
//   o_instr_valid  o_instr_out holds a fetched instruction (0 = bubble)
//   o_pc           address of the next word to fetch
//   o_busy         unit is not idle
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [15:0] NOP_WORD = 16'hA000,
    parameter int          PM_DEPTH = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic [7:0]  i_ld_data,
    input  logic        i_ld_valid,
    input  logic        i_ld_last,
    output logic        o_ld_ready,
    input  logic        i_jmp,
    input  logic [4:0]  i_jmp_addr,
    output logic [15:0] o_instr_out,
    output logic        o_instr_valid,
    output logic [4:0]  o_pc,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD_HI = 2'd1,
        S_LOAD_LO = 2'd2,
        S_RUN     = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [15:0] r_mem [PM_DEPTH];
    logic [4:0]  r_wptr;
    logic [7:0]  r_hi_byte;
    logic [4:0]  r_pc;
    logic [15:0] r_instr;
    logic        r_instr_valid;

    logic        w_accept;
    logic        w_wptr_clr;
    logic        w_hi_we;
    logic        w_mem_we;
    logic        w_start;
    logic        w_fetch;
    logic        w_jump;

    assign o_ld_ready    = (r_state == S_LOAD_HI) || (r_state == S_LOAD_LO);
    assign o_busy        = (r_state != S_IDLE);
    assign o_pc          = r_pc;
    assign o_instr_out   = r_instr;
    assign o_instr_valid = r_instr_valid;

    assign w_accept = o_ld_ready && i_ld_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus one-hot strobes that steer the datapath registers below.
    // STOP is checked first in every active state so it beats bytes and jumps.
    always_comb begin
        w_state_next = r_state;
        w_wptr_clr   = 1'b0;
        w_hi_we      = 1'b0;
        w_mem_we     = 1'b0;
        w_start      = 1'b0;
        w_fetch      = 1'b0;
        w_jump       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_load) begin
                    w_state_next = S_LOAD_HI;
                    w_wptr_clr   = 1'b1;
                end else if (i_start) begin
                    w_state_next = S_RUN;
                    w_start      = 1'b1;
                end
            end
            S_LOAD_HI: begin
                if (i_stop) begin
                    w_state_next = S_IDLE;
                end else if (w_accept) begin
                    w_hi_we      = 1'b1;
                    w_state_next = S_LOAD_LO;
                end
            end
            S_LOAD_LO: begin
                if (i_stop) begin
                    w_state_next = S_IDLE;
                end else if (w_accept) begin
                    w_mem_we     = 1'b1;
                    // A full memory ends the load even without LD_LAST.
                    w_state_next = (i_ld_last || (r_wptr == 5'd31)) ? S_IDLE : S_LOAD_HI;
                end
            end
            S_RUN: begin
                if (i_stop) begin
                    w_state_next = S_IDLE;
                end else if (i_jmp && r_instr_valid) begin
                    // Only a real instruction may jump; a bubble cannot.
                    w_jump = 1'b1;
                end else begin
                    w_fetch = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Loader pointer, holding byte, PC and the instruction output register.
    // Anything other than a plain fetch drives a NOP bubble, which covers
    // every non-RUN state as well as jump and stop cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr        <= 5'd0;
            r_hi_byte     <= 8'd0;
            r_pc          <= 5'd0;
            r_instr       <= NOP_WORD;
            r_instr_valid <= 1'b0;
        end else begin
            if (w_wptr_clr) begin
                r_wptr <= 5'd0;
            end else if (w_mem_we) begin
                r_wptr <= r_wptr + 5'd1;
            end
            if (w_hi_we) begin
                r_hi_byte <= i_ld_data;
            end
            if (w_fetch) begin
                r_instr       <= r_mem[r_pc];
                r_instr_valid <= 1'b1;
                r_pc          <= r_pc + 5'd1;
            end else begin
                r_instr       <= NOP_WORD;
                r_instr_valid <= 1'b0;
                if (w_start) begin
                    r_pc <= 5'd0;
                end else if (w_jump) begin
                    r_pc <= i_jmp_addr;
                end
            end
        end
    end

    // Program memory is never cleared; reset only blocks a same-cycle write.
    always_ff @(posedge i_clk) begin
        if (w_mem_we && !i_rst) begin
            r_mem[r_wptr] <= {r_hi_byte, i_ld_data};
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Directed testbench for instr_fetch: reset state, short program load and
//   run with a jump, stalled load, stop during load and run, full 32-word load
//   with PC wrap, and reset in the middle of a run.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        load;
    logic        start;
    logic        stop;
    logic [7:0]  ld_data;
    logic        ld_valid;
    logic        ld_last;
    logic        ld_ready;
    logic        jmp;
    logic [4:0]  jmp_addr;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic [4:0]  pc;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    instr_fetch #(
        .NOP_WORD (16'hA000),
        .PM_DEPTH (32)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_load        (load),
        .i_start       (start),
        .i_stop        (stop),
        .i_ld_data     (ld_data),
        .i_ld_valid    (ld_valid),
        .i_ld_last     (ld_last),
        .o_ld_ready    (ld_ready),
        .i_jmp         (jmp),
        .i_jmp_addr    (jmp_addr),
        .o_instr_out   (instr_out),
        .o_instr_valid (instr_valid),
        .o_pc          (pc),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then stable and inputs may change.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input int stalls);
        repeat (stalls) begin
            ld_valid = 1'b0;
            ld_data  = 8'($urandom);
            ld_last  = 1'($urandom);
            tick();
        end
        ld_valid = 1'b1;
        ld_data  = b;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    function automatic logic [15:0] wexp(input int i);
        logic [7:0] k;
        k = 8'(i);
        return {k + 8'h10, 8'hE0 ^ k};
    endfunction

    task automatic check_fetch(input string tag, input logic [15:0] word, input logic [4:0] next_pc);
        check({tag, "_instr"}, instr_out, word);
        check({tag, "_valid"}, 16'(instr_valid), 16'd1);
        check({tag, "_pc"}, 16'(pc), 16'(next_pc));
    endtask

    task automatic check_bubble(input string tag, input logic [4:0] exp_pc, input logic exp_busy);
        check({tag, "_instr"}, instr_out, 16'hA000);
        check({tag, "_valid"}, 16'(instr_valid), 16'd0);
        check({tag, "_pc"}, 16'(pc), 16'(exp_pc));
        check({tag, "_busy"}, 16'(busy), 16'(exp_busy));
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        ld_data  = 8'h00;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        jmp      = 1'b0;
        jmp_addr = 5'd0;
        tick();
        tick();

        // Reset state
        check_bubble("rst", 5'd0, 1'b0);
        check("rst_ldrdy", 16'(ld_ready), 16'd0);
        rst = 1'b0;

        // Three-word program load
        load = 1'b1;
        tick();
        load = 1'b0;
        check("ld_ready_on", 16'(ld_ready), 16'd1);
        check("ld_busy", 16'(busy), 16'd1);
        send_byte(8'h70, 1'b0, 0);
        send_byte(8'h05, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h2A, 1'b0, 0);
        send_byte(8'hF0, 1'b0, 0);
        send_byte(8'h00, 1'b1, 0);
        check("ld_done_rdy", 16'(ld_ready), 16'd0);
        check("ld_done_busy", 16'(busy), 16'd0);

        // Run: bubble, then words; jump on F000 back to 0
        start = 1'b1;
        tick();
        start = 1'b0;
        check_bubble("run_bubble", 5'd0, 1'b1);
        jmp      = 1'b1;   // must be ignored while the output is a bubble
        jmp_addr = 5'd9;
        tick();
        jmp = 1'b0;
        check_fetch("run0", 16'h7005, 5'd1);
        tick();
        check_fetch("run1", 16'h002A, 5'd2);
        tick();
        check_fetch("run2", 16'hF000, 5'd3);
        jmp      = 1'b1;
        jmp_addr = 5'd0;
        tick();
        jmp = 1'b0;
        check_bubble("jmp_bubble", 5'd0, 1'b1);
        tick();
        check_fetch("jmp_tgt", 16'h7005, 5'd1);

        // STOP and JMP in the same cycle: stop wins, PC holds
        stop     = 1'b1;
        jmp      = 1'b1;
        jmp_addr = 5'd5;
        tick();
        stop = 1'b0;
        jmp  = 1'b0;
        check_bubble("stop_jmp", 5'd1, 1'b0);

        // Stalled load; LOAD and START together (load wins); LD_LAST on a
        // high byte is ignored
        load  = 1'b1;
        start = 1'b1;
        tick();
        load  = 1'b0;
        start = 1'b0;
        check("ldst_ready", 16'(ld_ready), 16'd1);
        send_byte(8'h12, 1'b1, 2);
        send_byte(8'h34, 1'b0, 3);
        send_byte(8'hAB, 1'b0, 1);
        send_byte(8'hCD, 1'b0, 0);
        send_byte(8'h55, 1'b0, 2);
        send_byte(8'hAA, 1'b1, 1);
        check("stall_idle", 16'(busy), 16'd0);

        // STOP after a high byte, with a same-cycle low byte: nothing written
        load = 1'b1;
        tick();
        load = 1'b0;
        send_byte(8'h99, 1'b0, 0);
        stop     = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 8'h77;
        tick();
        stop     = 1'b0;
        ld_valid = 1'b0;
        check("ldstop_busy", 16'(busy), 16'd0);
        check("ldstop_rdy", 16'(ld_ready), 16'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_fetch("stall0", 16'h1234, 5'd1);
        tick();
        check_fetch("stall1", 16'hABCD, 5'd2);
        tick();
        check_fetch("stall2", 16'h55AA, 5'd3);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Full 32-word load without LD_LAST
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 32; i++) begin
            logic [15:0] w;
            w = wexp(i);
            send_byte(w[15:8], 1'b0, 0);
            send_byte(w[7:0], 1'b0, i % 3);
        end
        check("full_busy", 16'(busy), 16'd0);
        check("full_rdy", 16'(ld_ready), 16'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            check_fetch("full_run", wexp(i), 5'((i + 1) % 32));
            if (i == 10) load = 1'b1;   // ignored outside IDLE
            else load = 1'b0;
        end
        check("run_ldrdy", 16'(ld_ready), 16'd0);
        tick();
        check_fetch("wrap", wexp(0), 5'd1);
        for (int i = 1; i < 7; i++) tick();
        check_fetch("pc7", wexp(6), 5'd7);

        // Reset in the middle of a run
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_bubble("mid_rst", 5'd0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_bubble("rerun_bubble", 5'd0, 1'b1);
        tick();
        check_fetch("rerun0", wexp(0), 5'd1);
        tick();
        check_fetch("rerun1", wexp(1), 5'd2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("end_busy", 16'(busy), 16'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
